// File: rtl/step_pulse_gen.sv
// rtl/step_pulse_gen.sv - step pulse source: walk/jog/run/hybrid rates via fractional accumulator
// Optional hybrid schedule ROM enabled by defining HYBRID_SCHEDULE_EN.
module step_pulse_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] mode,
  output logic       pulse,
  output logic       second_tick,
  output logic [7:0] rate,
  output logic [7:0] sec_idx
);

  localparam int AW = $clog2(CLK_HZ + 256);
  localparam int CW = $clog2(CLK_HZ + 1);
  localparam logic [AW-1:0] CLK_ACC = AW'(CLK_HZ);
  localparam logic [CW-1:0] CLK_CYC = CW'(CLK_HZ);
  localparam logic [7:0]    SEC_MAX = 8'd145;

  logic [CW-1:0] cyc;
  logic [AW-1:0] acc;
  logic [1:0]    mode_q;

  logic [AW-1:0] acc_sum;
  logic          hit;
  logic          active;
  logic          last_cyc;
  logic [1:0]    next_mode;
  logic [7:0]    next_idx;
  logic [7:0]    next_rate;

`ifdef HYBRID_SCHEDULE_EN
  function automatic logic [7:0] hybrid_rate(input logic [7:0] idx);
    logic [7:0] r;
    r = 8'd0;
    case (idx)
      8'd1: r = 8'd20;
      8'd2: r = 8'd33;
      8'd3: r = 8'd66;
      8'd4: r = 8'd27;
      8'd5: r = 8'd70;
      8'd6: r = 8'd30;
      8'd7: r = 8'd19;
      8'd8: r = 8'd30;
      8'd9: r = 8'd33;
      default: begin
        if (idx >= 8'd10 && idx <= 8'd73)       r = 8'd69;
        else if (idx >= 8'd74 && idx <= 8'd79)  r = 8'd34;
        else if (idx >= 8'd80 && idx <= 8'd144) r = 8'd124;
      end
    endcase
    return r;
  endfunction
`endif

  // sec_idx is never 0 while running, so it doubles as the run flag
  always_comb begin
    active    = (sec_idx != 8'd0);
    last_cyc  = (cyc == CLK_CYC);
    acc_sum   = acc + AW'(rate);
    hit       = (acc_sum >= CLK_ACC);
    next_mode = mode_q;
    next_idx  = 8'd1;
    next_rate = 8'd0;
    if (!active || (mode != mode_q)) begin
      next_mode = mode;
      next_idx  = 8'd1;
    end else begin
      next_mode = mode_q;
      next_idx  = (sec_idx >= SEC_MAX) ? SEC_MAX : sec_idx + 8'd1;
    end
    case (next_mode)
      2'b00:   next_rate = 8'd32;
      2'b01:   next_rate = 8'd64;
      2'b10:   next_rate = 8'd128;
      default: begin
`ifdef HYBRID_SCHEDULE_EN
        next_rate = hybrid_rate(next_idx);
`else
        next_rate = 8'd0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse       <= 1'b0;
      second_tick <= 1'b0;
      rate        <= 8'd0;
      sec_idx     <= 8'd0;
      cyc         <= '0;
      acc         <= '0;
      mode_q      <= 2'b00;
    end else if (!start) begin
      pulse       <= 1'b0;
      second_tick <= 1'b0;
      rate        <= 8'd0;
      sec_idx     <= 8'd0;
      cyc         <= '0;
      acc         <= '0;
      mode_q      <= 2'b00;
    end else if (!active) begin
      pulse       <= 1'b0;
      second_tick <= 1'b0;
      rate        <= next_rate;
      sec_idx     <= next_idx;
      mode_q      <= next_mode;
      cyc         <= CW'(1);
      acc         <= '0;
    end else begin
      pulse <= hit;
      acc   <= hit ? (acc_sum - CLK_ACC) : acc_sum;
      // window boundary: new rate takes effect for the first cycle of the next window
      if (last_cyc) begin
        second_tick <= 1'b1;
        cyc         <= CW'(1);
        acc         <= '0;
        rate        <= next_rate;
        sec_idx     <= next_idx;
        mode_q      <= next_mode;
      end else begin
        second_tick <= 1'b0;
        cyc         <= cyc + CW'(1);
      end
    end
  end

endmodule
